alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered ALU with a valid/ready handshake and NZCV flag generation.
//  Generalises the 2-bit-op combinational ALU:
//   - WIDTH-bit datapath, 8 ops, flags.
//   - Optional iterative multiplier.
//  Sits between the decode/register-read stage and write-back of the micro ARM core.
//  Later cores with stall-capable pipelines use it in place of the combinational ALU.
// PARAMETERS
//  WIDTH     32  datapath width in bits; >=4, power of 2
//  SHW       $clog2(WIDTH)  shift-amount width (derived, do not override)
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operand/op presented
//  in_ready   out  1      block can accept; transfer when in_valid && in_ready
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shift amount = b[SHW-1:0] for shifts)
//  op         in   3      0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 LSL, 6 LSR, 7 MUL
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts; transfer when out_valid && out_ready
//  result     out  WIDTH  registered result
//  flags      out  4      {N,Z,C,V}, registered with result
//  busy       out  1      high while a MUL iteration is in progress
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; out_valid=0; result=0; flags=0; busy=0.
//    in_ready is combinational and therefore 0 during reset.
//  - Reset mid-MUL or mid-HOLD aborts the operation; the result is discarded.
//  - FSM states:
//    - IDLE: in_ready=1.
//    - HOLD: out_valid=1; in_ready=out_ready.
//    - MULT: busy=1; in_ready=0; out_valid=0.
//  - IDLE/HOLD, accept of op 0-6:
//    - Result and flags computed combinationally, registered at the accepting edge.
//    - Next state HOLD; latency 1 cycle.
//  - HOLD, out_ready=1 with no new accept: next state IDLE, out_valid=0.
//  - HOLD, simultaneous drain and accept: state stays HOLD with the new result.
//    Back-to-back throughput is 1 op/cycle.
//  - HOLD, out_ready=0: result/flags stay stable; in_ready=0.
//  - Accept of op 7: loads multiplicand, multiplier and counter=WIDTH; next state MULT.
//  - MULT:
//    - One shift-add step per cycle; counter decrements each cycle.
//    - At counter==1 the low WIDTH bits are written to result; next state HOLD.
//    - Accept-to-out_valid latency = WIDTH cycles.
//  - Arithmetic, all modulo 2^WIDTH:
//    - ADD: C = carry out; V = signed overflow.
//    - SUB: a-b; C = NOT borrow (ARM convention, a>=b unsigned); V = signed overflow.
//    - AND/ORR/EOR: C=0, V=0.
//    - LSL/LSR: amount 0 gives result=a, C=0.
//      Otherwise C = last bit shifted out; V=0. Amounts >= WIDTH are impossible by port width.
//    - MUL: low WIDTH bits; C=0, V=0.
//    - All ops: N = result[WIDTH-1]; Z = (result==0).
//  - Input pins are don't-care when in_valid=0.
//    Operands are captured at accept, so input changes during MULT have no effect.
// CONFIGURATION
//  ALU_SEQ_MUL_EN
//   - Defined: MULT state and iterative multiplier are compiled in, as described above.
//   - Undefined: no MULT state or multiplier logic; busy is tied 0.
//     op 7 is handled as a 1-cycle op: result=0, flags={0,1,0,0}.
// TESTING
//  - Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, result=0, flags=0, in_ready=0.
//  - ADD overflow (WIDTH=32): a=7FFF_FFFF, b=1, op=0 -> next cycle result=8000_0000, flags=1001.
//  - SUB equal: a=b=5, op=1 -> result=0, flags=0110.
//    Then a=3, b=5 -> result=FFFF_FFFE, flags=1000.
//  - Back-pressure and streaming:
//    - ADD 1+1 accepted with out_ready=0 for 3 cycles -> result=2 held stable, in_ready=0.
//    - Release, then stream 3 ORRs with out_ready=1 -> one result per cycle, in order.
//  - LSR carry: a=0000_0003, b=1, op=6 -> result=1, flags=0010.
//    LSL with b=0 -> result=a, C=0.
//  - MUL (macro defined, WIDTH=32): a=0001_0001, b=0001_0001 -> busy for 32 cycles, in_ready=0.
//    Then result=0002_0001, flags=0000.
//    Repeat with rst_n pulsed mid-MUL -> out_valid never asserts.
//    Macro undefined: op 7 -> result=0, flags=0100 after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshake and NZCV flags.
// Ops: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 LSL, 6 LSR, 7 MUL.
// Optional iterative multiplier enabled by defining ALU_SEQ_MUL_EN; without it
// op 7 completes in one cycle with result=0 and flags={0,1,0,0}.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake (a, b, op)
//   out_valid/out_ready   result handshake (result, flags={N,Z,C,V})
//   busy                  high while a MUL iteration is in progress
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1
`ifdef ALU_SEQ_MUL_EN
        ,
        MULT = 2'd2
`endif
    } state_t;

    state_t state, state_nx;
    logic   load_alu;

    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   add_w, sub_w, lsl_w, lsr_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    assign amt = b[SHW-1:0];

    // The extra bit on each shift vector catches the last bit shifted out,
    // which also yields C=0 naturally for a zero shift amount.
    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        lsl_w   = {1'b0, a} << amt;
        lsr_w   = {a, 1'b0} >> amt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            3'd0: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = ~sub_w[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2: alu_res = a & b;
            3'd3: alu_res = a | b;
            3'd4: alu_res = a ^ b;
            3'd5: begin
                alu_res = lsl_w[WIDTH-1:0];
                alu_c   = lsl_w[WIDTH];
            end
            3'd6: begin
                alu_res = lsr_w[WIDTH:1];
                alu_c   = lsr_w[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    logic             load_mul, mul_done;
    logic [WIDTH-1:0] mcand, mplier, acc, mul_sum;
    logic [SHW:0]     cnt;

    assign mul_sum = acc + (mplier[0] ? mcand : '0);
`endif

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load_alu  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        load_mul  = 1'b0;
        mul_done  = 1'b0;
`endif
        case (state)
            IDLE: in_ready = rst_n;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = rst_n && out_ready;
                if (out_ready)
                    state_nx = IDLE;
            end
`ifdef ALU_SEQ_MUL_EN
            MULT: begin
                busy = 1'b1;
                if (cnt == CNT_ONE) begin
                    mul_done = 1'b1;
                    state_nx = HOLD;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
        // An accept overrides the drain-to-IDLE decision so HOLD can stream.
        if (in_valid && in_ready) begin
`ifdef ALU_SEQ_MUL_EN
            if (op == 3'd7) begin
                load_mul = 1'b1;
                state_nx = MULT;
            end else begin
                load_alu = 1'b1;
                state_nx = HOLD;
            end
`else
            load_alu = 1'b1;
            state_nx = HOLD;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            flags  <= '0;
`ifdef ALU_SEQ_MUL_EN
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
`endif
        end else begin
            state <= state_nx;
            if (load_alu) begin
                result <= alu_res;
                flags  <= {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
            end
`ifdef ALU_SEQ_MUL_EN
            if (load_mul) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                cnt    <= CNT_INIT;
            end else if (state == MULT) begin
                acc    <= mul_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CNT_ONE;
                if (mul_done) begin
                    result <= mul_sum;
                    flags  <= {mul_sum[WIDTH-1], mul_sum == '0, 2'b00};
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] res;
        logic [3:0]   fl;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [2:0] vop,
                           input logic [W-1:0] vres, input logic [3:0] vfl);
        vec_t v;
        v.a = va; v.b = vb; v.op = vop; v.res = vres; v.fl = vfl;
        vecs.push_back(v);
    endtask

    initial begin
        int busy_cnt;
        int bad_ready;
        int seen;

        // {a, b, op} -> {result, flags NZCV}
        add_vec(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 32'h8000_0000, 4'b1001);
        add_vec(32'h0000_0005, 32'h0000_0005, 3'd1, 32'h0000_0000, 4'b0110);
        add_vec(32'h0000_0003, 32'h0000_0005, 3'd1, 32'hFFFF_FFFE, 4'b1000);
        add_vec(32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 32'h0000_0000, 4'b0110);
        add_vec(32'h8000_0000, 32'h0000_0001, 3'd1, 32'h7FFF_FFFF, 4'b0011);
        add_vec(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, 32'hF000_F000, 4'b1000);
        add_vec(32'h0000_000F, 32'h0000_00F0, 3'd3, 32'h0000_00FF, 4'b0000);
        add_vec(32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'd4, 32'h0000_0000, 4'b0100);
        add_vec(32'h0000_0003, 32'h0000_0001, 3'd6, 32'h0000_0001, 4'b0010);
        add_vec(32'h1234_5678, 32'h0000_0000, 3'd5, 32'h1234_5678, 4'b0000);
        add_vec(32'h8000_0001, 32'h0000_0001, 3'd5, 32'h0000_0002, 4'b0010);
        add_vec(32'h8000_0000, 32'h0000_001F, 3'd6, 32'h0000_0001, 4'b0000);
        add_vec(32'h0000_0001, 32'h0000_001F, 3'd5, 32'h8000_0000, 4'b1000);
        add_vec(32'h0000_0003, 32'h0000_0021, 3'd5, 32'h0000_0006, 4'b0000);
`ifndef ALU_SEQ_MUL_EN
        add_vec(32'h0000_0005, 32'h0000_0005, 3'd7, 32'h0000_0000, 4'b0100);
`endif

        // Reset held for 2 cycles with a request presented.
        rst_n = 1'b0; in_valid = 1'b1; a = 32'd1; b = 32'd1; op = 3'd0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_result", result, '0);
        chk("rst_flags", W'(flags), '0);
        chk("rst_in_ready", W'(in_ready), '0);
        chk("rst_busy", W'(busy), '0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();

        // Table: streamed with out_ready=1, one op per cycle.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; in_valid = 1'b1;
            chk($sformatf("v%0d_in_ready", i), W'(in_ready), W'(1));
            tick();
            chk($sformatf("v%0d_out_valid", i), W'(out_valid), W'(1));
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_flags", i), W'(flags), W'(vecs[i].fl));
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", W'(out_valid), '0);

        // Back-pressure: ADD 1+1 held for 3 cycles while another op waits.
        out_ready = 1'b0;
        a = 32'd1; b = 32'd1; op = 3'd0; in_valid = 1'b1;
        tick();
        a = 32'd5; b = 32'd5;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_out_valid", i), W'(out_valid), W'(1));
            chk($sformatf("bp%0d_result", i), result, 32'd2);
            chk($sformatf("bp%0d_in_ready", i), W'(in_ready), '0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", W'(out_valid), '0);

        // Stream 3 ORRs back to back.
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 << i; b = 32'(i + 1); op = 3'd3; in_valid = 1'b1;
            tick();
            chk($sformatf("orr%0d_out_valid", i), W'(out_valid), W'(1));
            chk($sformatf("orr%0d_result", i), result, (32'h100 << i) | 32'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        chk("orr_drain", W'(out_valid), '0);

`ifdef ALU_SEQ_MUL_EN
        // Iterative multiply: busy for WIDTH cycles, pins ignored meanwhile.
        out_ready = 1'b0;
        a = 32'h0001_0001; b = 32'h0001_0001; op = 3'd7; in_valid = 1'b1;
        tick();
        a = 32'hFFFF_FFFF; b = 32'h1234_5678; op = 3'd0;
        busy_cnt = 0; bad_ready = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            if (busy) busy_cnt++;
            if (in_ready) bad_ready++;
            tick();
        end
        chk("mul_out_valid", W'(out_valid), W'(1));
        chk("mul_busy_cycles", W'(busy_cnt), W'(32));
        chk("mul_in_ready_low", W'(bad_ready), '0);
        chk("mul_result", result, 32'h0002_0001);
        chk("mul_flags", W'(flags), '0);
        chk("mul_hold_in_ready", W'(in_ready), '0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("mul_drain", W'(out_valid), '0);

        // Multiply aborted by reset: no result ever appears.
        a = 32'h0001_0001; b = 32'h0001_0001; op = 3'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("mulrst_busy_before", W'(busy), W'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) seen++;
            tick();
        end
        chk("mulrst_no_valid", W'(seen), '0);
        chk("mulrst_result", result, '0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
